// File: rtl/ahb_slave_pipe_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_pipe_if
//   Bundles the AHB-side and APB-controller-side signals of the AHB slave
//   front end so that the bridge top level and the bench connect through a
//   single port.
//
//   Handshake semantics: a transfer is offered when Htrans[1] and Hreadyin
//   are both high. The front end accepts it (and every pipeline stage
//   shifts) on a rising clock edge where Hreadyout is high and err_hold is
//   low. While err_hold is high the master HREADY is pulled low at the top
//   level, so the master keeps its address phase stable.
//
//   Modports:
//     slave  : the front end (ahb_slave_pipe) - consumes bus inputs,
//              drives decode, pipeline and response outputs.
//     master : the driving side (bridge top level or bench).
//
//   err_state is a debug view of the error FSM state
//   (0 IDLE, 1 ERR1, 2 ERR2; always 0 when the error FSM is absent).
// ----------------------------------------------------------------------------
interface ahb_slave_pipe_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SEL = 3
);
   logic                Hwrite;
   logic                Hreadyin;
   logic [1:0]          Htrans;
   logic [ADDR_W-1:0]   Haddr;
   logic [DATA_W-1:0]   Hwdata;
   logic                Hreadyout;
   logic                valid;
   logic [NUM_SEL-1:0]  Temp_selx;
   logic [ADDR_W-1:0]   H_addr1;
   logic [ADDR_W-1:0]   H_addr2;
   logic [ADDR_W-1:0]   H_addrw;
   logic [DATA_W-1:0]   H_wdata1;
   logic [DATA_W-1:0]   H_wdata2;
   logic                Hwritereg;
   logic [NUM_SEL-1:0]  H_selw;
   logic [1:0]          Hresp;
   logic                err_hold;
   logic [1:0]          err_state;

   modport slave (
      input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Hreadyout,
      output valid, Temp_selx, H_addr1, H_addr2, H_addrw, H_wdata1, H_wdata2,
             Hwritereg, H_selw, Hresp, err_hold, err_state
   );

   modport master (
      output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Hreadyout,
      input  valid, Temp_selx, H_addr1, H_addr2, H_addrw, H_wdata1, H_wdata2,
             Hwritereg, H_selw, Hresp, err_hold, err_state
   );
endinterface

// File: rtl/ahb_slave_pipe.sv
// ----------------------------------------------------------------------------
// ahb_slave_pipe
//   AHB slave-side front end of the AHB-to-APB bridge. Decodes the bridge
//   address window into NUM_SEL one-hot peripheral selects, raises valid
//   towards the APB controller and pipelines address / write data /
//   direction / select through registered stages enabled by Hreadyout.
//
//   Ports:
//     Hclk     : clock, all state on the rising edge
//     Hresetn  : synchronous active-low reset
//     bus      : ahb_slave_pipe_if.slave - AHB inputs, Hreadyout, decode,
//                pipeline stages, Hresp, err_hold and err_state debug view
//
//   Optional feature (macro AHB_SLAVE_PIPE_ERR_RESP_EN):
//     defined     - in-window transfers to unmapped slots get a two-cycle
//                   AHB ERROR response from a small FSM and do not raise
//                   valid; the pipeline freezes during the first ERROR cycle.
//     not defined - no FSM; Hresp is OKAY, err_hold is 0 and any in-window
//                   active transfer raises valid.
// ----------------------------------------------------------------------------
module ahb_slave_pipe #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                NUM_SEL      = 3,
   parameter int                WIN_SLOTS    = 4,
   parameter int                REGION_SHIFT = 26,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h8000_0000)
) (
   input logic             Hclk,
   input logic             Hresetn,
   ahb_slave_pipe_if.slave bus
);

   localparam int IDX_W = ADDR_W - REGION_SHIFT;
   localparam logic [IDX_W-1:0] WIN_LIM = IDX_W'(WIN_SLOTS);
   localparam logic [IDX_W-1:0] SEL_LIM = IDX_W'(NUM_SEL);

   logic [IDX_W-1:0]   idx;
   logic               in_window;
   logic               mapped;
   logic               active;
   logic               pen;
   logic [NUM_SEL-1:0] sel_dec;
   logic               unused_htrans0;

   // Subtraction wraps; the full-width compare against BASE_ADDR rejects
   // low addresses whose wrapped index would otherwise look in-window.
   assign idx       = bus.Haddr[ADDR_W-1:REGION_SHIFT] - BASE_ADDR[ADDR_W-1:REGION_SHIFT];
   assign in_window = (bus.Haddr >= BASE_ADDR) && (idx < WIN_LIM);
   assign mapped    = in_window && (idx < SEL_LIM);
   // NONSEQ and SEQ both have Htrans[1] set; bit 0 carries no extra meaning here.
   assign active    = bus.Htrans[1] & bus.Hreadyin;
   assign unused_htrans0 = bus.Htrans[0];

   // Address-only decode; Htrans is deliberately ignored.
   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < NUM_SEL; i++) begin
         if (mapped && (idx == IDX_W'(i))) begin
            sel_dec[i] = 1'b1;
         end
      end
   end

   assign bus.Temp_selx = sel_dec;

   // ---------------------------------------------------------------------
   // Pipeline stages
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0]  addr1_q, addr2_q, addrw_q;
   logic [DATA_W-1:0]  wdata1_q, wdata2_q;
   logic               write1_q, write2_q;
   logic [NUM_SEL-1:0] sel1_q, sel2_q;

   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         addr1_q  <= '0;
         addr2_q  <= '0;
         addrw_q  <= '0;
         wdata1_q <= '0;
         wdata2_q <= '0;
         write1_q <= 1'b0;
         write2_q <= 1'b0;
         sel1_q   <= '0;
         sel2_q   <= '0;
      end else if (pen) begin
         addr1_q  <= bus.Haddr;
         addr2_q  <= addr1_q;
         addrw_q  <= addr2_q;
         wdata1_q <= bus.Hwdata;
         wdata2_q <= wdata1_q;
         write1_q <= bus.Hwrite;
         write2_q <= write1_q;
         sel1_q   <= sel_dec;
         sel2_q   <= sel1_q;
      end
   end

   assign bus.H_addr1   = addr1_q;
   assign bus.H_addr2   = addr2_q;
   assign bus.H_addrw   = addrw_q;
   assign bus.H_wdata1  = wdata1_q;
   assign bus.H_wdata2  = wdata2_q;
   assign bus.Hwritereg = write2_q;
   assign bus.H_selw    = sel2_q;

   // ---------------------------------------------------------------------
   // Error response
   // ---------------------------------------------------------------------
`ifdef AHB_SLAVE_PIPE_ERR_RESP_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } err_state_e;

   err_state_e state_q, state_d;
   logic       unmapped_hit;
   logic       err_hold;
   logic [1:0] hresp;

   assign unmapped_hit = active & in_window & ~mapped;

   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      err_hold = 1'b0;
      hresp    = 2'b00;
      case (state_q)
         IDLE: begin
            // A hit with Hreadyout low is simply re-seen next cycle because
            // the master keeps its address phase.
            if (unmapped_hit && bus.Hreadyout) begin
               state_d = ERR1;
            end
         end
         ERR1: begin
            hresp    = 2'b01;
            err_hold = 1'b1;
            state_d  = ERR2;
         end
         ERR2: begin
            hresp   = 2'b01;
            state_d = unmapped_hit ? ERR1 : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.valid     = active & mapped;
   assign bus.Hresp     = hresp;
   assign bus.err_hold  = err_hold;
   assign bus.err_state = state_q;
   assign pen           = bus.Hreadyout & ~err_hold;
`else
   assign bus.valid     = active & in_window;
   assign bus.Hresp     = 2'b00;
   assign bus.err_hold  = 1'b0;
   assign bus.err_state = 2'b00;
   assign pen           = bus.Hreadyout;
`endif

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_pipe
//   Directed bench for ahb_slave_pipe at default parameters. A decode table
//   is applied in a loop; pipeline, stall and error sequences are written out
//   by hand with their expected stage contents.
// ----------------------------------------------------------------------------
module tb_ahb_slave_pipe;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 3;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb_slave_pipe_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS)) bus ();

   ahb_slave_pipe #(.ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS)) dut (
      .Hclk    (clk),
      .Hresetn (rst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  htrans;
      logic        hreadyin;
      logic [2:0]  exp_sel;
      logic        exp_valid;
   } dec_vec_t;

   dec_vec_t vecs[10];

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_pipe(input string tag,
                             input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] aw, input logic [31:0] d1,
                             input logic [31:0] d2, input logic wr,
                             input logic [2:0] selw);
      check({tag, ".H_addr1"},   64'(bus.H_addr1),   64'(a1));
      check({tag, ".H_addr2"},   64'(bus.H_addr2),   64'(a2));
      check({tag, ".H_addrw"},   64'(bus.H_addrw),   64'(aw));
      check({tag, ".H_wdata1"},  64'(bus.H_wdata1),  64'(d1));
      check({tag, ".H_wdata2"},  64'(bus.H_wdata2),  64'(d2));
      check({tag, ".Hwritereg"}, 64'(bus.Hwritereg), 64'(wr));
      check({tag, ".H_selw"},    64'(bus.H_selw),    64'(selw));
   endtask

   task automatic check_resp(input string tag, input logic [1:0] resp, input logic hold);
      check({tag, ".Hresp"},    64'(bus.Hresp),    64'(resp));
      check({tag, ".err_hold"}, 64'(bus.err_hold), 64'(hold));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic write, input logic [1:0] htrans);
      bus.Haddr    = addr;
      bus.Hwdata   = wdata;
      bus.Hwrite   = write;
      bus.Htrans   = htrans;
      bus.Hreadyin = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      rst_n         = 1'b0;
      bus.Haddr     = $urandom;
      bus.Hwdata    = $urandom;
      bus.Hwrite    = 1'($urandom_range(0, 1));
      bus.Htrans    = 2'($urandom_range(0, 3));
      bus.Hreadyin  = 1'($urandom_range(0, 1));
      bus.Hreadyout = 1'b1;
      tick();
      tick();
      check_pipe(tag, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000);
      check_resp(tag, 2'b00, 1'b0);
      rst_n = 1'b1;
      drive(32'h0, 32'h0, 1'b0, T_IDLE);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.Haddr     = '0;
      bus.Hwdata    = '0;
      bus.Hwrite    = 1'b0;
      bus.Htrans    = T_IDLE;
      bus.Hreadyin  = 1'b1;
      bus.Hreadyout = 1'b1;

      vecs[0] = '{32'h8000_0000, T_NONSEQ, 1'b1, 3'b001, 1'b1};
      vecs[1] = '{32'h8400_0010, T_NONSEQ, 1'b1, 3'b010, 1'b1};
      vecs[2] = '{32'h8BFF_FFFC, T_NONSEQ, 1'b1, 3'b100, 1'b1};
      vecs[3] = '{32'h9000_0000, T_NONSEQ, 1'b1, 3'b000, 1'b0};
      vecs[4] = '{32'h8000_0000, T_IDLE,   1'b1, 3'b001, 1'b0};
      vecs[5] = '{32'h8400_0000, T_SEQ,    1'b1, 3'b010, 1'b1};
      vecs[6] = '{32'h8400_0000, T_BUSY,   1'b1, 3'b010, 1'b0};
      vecs[7] = '{32'h8000_0000, T_NONSEQ, 1'b0, 3'b001, 1'b0};
      vecs[8] = '{32'h7FFF_FFFC, T_NONSEQ, 1'b1, 3'b000, 1'b0};
`ifdef AHB_SLAVE_PIPE_ERR_RESP_EN
      vecs[9] = '{32'h8C00_0000, T_NONSEQ, 1'b1, 3'b000, 1'b0};
`else
      vecs[9] = '{32'h8C00_0000, T_NONSEQ, 1'b1, 3'b000, 1'b1};
`endif

      // ---- reset ----
      do_reset("reset");

      // ---- decode table ----
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].addr, 32'h0, 1'b0, vecs[i].htrans);
         bus.Hreadyin = vecs[i].hreadyin;
         #1;
         check($sformatf("dec%0d.Temp_selx", i), 64'(bus.Temp_selx), 64'(vecs[i].exp_sel));
         check($sformatf("dec%0d.valid", i),     64'(bus.valid),     64'(vecs[i].exp_valid));
         tick();
      end

      // ---- back-to-back pipeline with a 3-cycle stall ----
      do_reset("reset2");
      drive(32'h8000_0004, 32'h1111_1111, 1'b1, T_NONSEQ);
      tick();
      check_pipe("pipe_e1", 32'h8000_0004, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 1'b0, 3'b000);
      drive(32'h8000_0008, 32'h2222_2222, 1'b1, T_NONSEQ);
      tick();
      check_pipe("pipe_e2", 32'h8000_0008, 32'h8000_0004, 32'h0,
                 32'h2222_2222, 32'h1111_1111, 1'b1, 3'b001);
      drive(32'h8000_000C, 32'h3333_3333, 1'b1, T_NONSEQ);
      tick();
      check_pipe("pipe_e3", 32'h8000_000C, 32'h8000_0008, 32'h8000_0004,
                 32'h3333_3333, 32'h2222_2222, 1'b1, 3'b001);
      drive(32'h8400_0000, 32'h4444_4444, 1'b0, T_IDLE);
      bus.Hreadyout = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         check_pipe($sformatf("stall%0d", s), 32'h8000_000C, 32'h8000_0008, 32'h8000_0004,
                    32'h3333_3333, 32'h2222_2222, 1'b1, 3'b001);
      end
      bus.Hreadyout = 1'b1;
      tick();
      check_pipe("resume1", 32'h8400_0000, 32'h8000_000C, 32'h8000_0008,
                 32'h4444_4444, 32'h3333_3333, 1'b1, 3'b001);
      tick();
      check_pipe("resume2", 32'h8400_0000, 32'h8400_0000, 32'h8000_000C,
                 32'h4444_4444, 32'h4444_4444, 1'b0, 3'b010);

`ifdef AHB_SLAVE_PIPE_ERR_RESP_EN
      // ---- single ERROR response, pipeline frozen in ERR1 ----
      do_reset("reset3");
      drive(32'h8000_0010, 32'hAAAA_0001, 1'b1, T_NONSEQ);
      tick();
      drive(32'h8C00_0000, 32'hBBBB_0002, 1'b0, T_NONSEQ);
      #1;
      check("err.valid", 64'(bus.valid), 64'(1'b0));
      check("err.Temp_selx", 64'(bus.Temp_selx), 64'(3'b000));
      check_resp("err_pre", 2'b00, 1'b0);
      tick();
      check_resp("err1", 2'b01, 1'b1);
      check("err1.err_state", 64'(bus.err_state), 64'(2'd1));
      check_pipe("err1", 32'h8C00_0000, 32'h8000_0010, 32'h0,
                 32'hBBBB_0002, 32'hAAAA_0001, 1'b1, 3'b001);
      drive(32'h8400_0000, 32'hCCCC_0003, 1'b1, T_IDLE);
      tick();
      check_resp("err2", 2'b01, 1'b0);
      check_pipe("err2", 32'h8C00_0000, 32'h8000_0010, 32'h0,
                 32'hBBBB_0002, 32'hAAAA_0001, 1'b1, 3'b001);
      tick();
      check_resp("err_done", 2'b00, 1'b0);
      check_pipe("err_done", 32'h8400_0000, 32'h8C00_0000, 32'h8000_0010,
                 32'hCCCC_0003, 32'hBBBB_0002, 1'b0, 3'b000);

      // ---- back-to-back unmapped hits: hit in ERR2 re-enters ERR1 ----
      do_reset("reset4");
      drive(32'h8C00_0000, 32'h0, 1'b0, T_NONSEQ);
      tick();
      check_resp("b2b_err1a", 2'b01, 1'b1);
      tick();
      check_resp("b2b_err2a", 2'b01, 1'b0);
      tick();
      check_resp("b2b_err1b", 2'b01, 1'b1);
      drive(32'h8C00_0000, 32'h0, 1'b0, T_IDLE);
      tick();
      check_resp("b2b_err2b", 2'b01, 1'b0);
      tick();
      check_resp("b2b_idle", 2'b00, 1'b0);

      // ---- hit with Hreadyout low waits, then reset aborts ERR1 ----
      do_reset("reset5");
      bus.Hreadyout = 1'b0;
      drive(32'h8C00_0000, 32'h5555_5555, 1'b0, T_NONSEQ);
      tick();
      check_resp("stallhit0", 2'b00, 1'b0);
      tick();
      check_resp("stallhit1", 2'b00, 1'b0);
      bus.Hreadyout = 1'b1;
      tick();
      check_resp("stallhit_err1", 2'b01, 1'b1);
      rst_n = 1'b0;
      tick();
      check_resp("rst_in_err1", 2'b00, 1'b0);
      check("rst_in_err1.H_addr1", 64'(bus.H_addr1), 64'(32'h0));
      rst_n = 1'b1;
`else
      // ---- unmapped in-window slot without the error response ----
      do_reset("reset3");
      drive(32'h8C00_0000, 32'h1234_5678, 1'b1, T_NONSEQ);
      #1;
      check("noerr.valid", 64'(bus.valid), 64'(1'b1));
      check("noerr.Temp_selx", 64'(bus.Temp_selx), 64'(3'b000));
      check_resp("noerr_pre", 2'b00, 1'b0);
      tick();
      check_resp("noerr_e1", 2'b00, 1'b0);
      check("noerr_e1.H_addr1", 64'(bus.H_addr1), 64'(32'h8C00_0000));
      tick();
      check_resp("noerr_e2", 2'b00, 1'b0);
      check_pipe("noerr_e2", 32'h8C00_0000, 32'h8C00_0000, 32'h0,
                 32'h1234_5678, 32'h1234_5678, 1'b1, 3'b000);
`endif

      // ---- final report ----
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
